nivel2: RTL and testbench

Parametrised microwave-oven controller, successor to the level-1 controller. Accepts digits from a one-hot keypad, counts the entered time down at one step per second, drives the magnetron with a selectable power level (duty cycle), and shows the remaining time on seven-segment digits. Sits at the top of the oven datapath between the keypad/buttons/door switch and the display and magnetron drivers.

---
 rtl/nivel2_pkg.sv | 37 +++
 rtl/nivel2_bcd_to_7seg.sv | 18 +
 rtl/nivel2.sv | 215 +++++++++++++++++++++
 tb/tb_nivel2.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nivel2_pkg.sv
// Shared definitions for the nivel2 microwave controller: state encodings,
// BCD digit width, seven-segment table and small keypad/power helpers.
package nivel2_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOK  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high, indexed by digit value.
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  function automatic logic is_onehot10(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [BCD_W-1:0] key_digit(input logic [9:0] v);
    logic [BCD_W-1:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      d = v[i] ? BCD_W'(i) : d;
    end
    return d;
  endfunction

  function automatic logic [3:0] clamp_power(input logic [3:0] p);
    return (p > 4'd9) ? 4'd9 : p;
  endfunction

endpackage

// File: rtl/nivel2_bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder; codes above 9 blank the digit.
module bcd_to_7seg
  import nivel2_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [6:0]       o_seg
);

  always_comb begin
    o_seg = 7'd0;
    if (i_bcd <= 4'd9) begin
      o_seg = SEG_TABLE[i_bcd];
    end else begin
      o_seg = 7'd0;
    end
  end

endmodule

// File: rtl/nivel2.sv
// nivel2 microwave controller: keypad entry, per-second countdown, duty-cycled
// magnetron and seven-segment display. Define DONE_BEEP_EN for the completion beeper.
module nivel2
  import nivel2_pkg::*;
#(
  parameter int TICK_DIV   = 1000,
  parameter int MIN_DIGITS = 1,
  parameter int BEEP_SECS  = 3
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [9:0]              keypad,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    door_closed,
  input  logic [3:0]              power,
  output logic [6:0]              sec_ones,
  output logic [6:0]              sec_tens,
  output logic [7*MIN_DIGITS-1:0] mins,
  output logic                    mag_on,
  output logic                    done,
  output logic                    beep
);

  localparam int ND      = MIN_DIGITS + 2;
  localparam int SUB_DIV = TICK_DIV / 10;
  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int SDIV_W  = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(SUB_DIV - 1);

  logic [9:0]       r_key;
  logic [9:0]       r_key_prev;
  logic             r_startn;
  logic             r_startn_prev;
  logic             r_stopn;
  logic             r_stopn_prev;
  logic             r_door;
  logic [3:0]       r_power;

  state_t           r_state;
  logic [BCD_W-1:0] r_dig [ND];
  logic [TICK_W-1:0] r_tick;
  logic [SDIV_W-1:0] r_sdiv;
  logic [3:0]       r_sub;
  logic [3:0]       r_power_lat;

  logic             w_start;
  logic             w_stop;
  logic             w_key_press;
  logic [BCD_W-1:0] w_key_digit;
  logic             w_time_zero;
  logic             w_dec_zero;
  logic [BCD_W-1:0] w_dec [ND];

  always_ff @(posedge clock) begin
    if (clear) begin
      r_key         <= 10'd0;
      r_key_prev    <= 10'd0;
      r_startn      <= 1'b1;
      r_startn_prev <= 1'b1;
      r_stopn       <= 1'b1;
      r_stopn_prev  <= 1'b1;
      r_door        <= 1'b0;
      r_power       <= 4'd0;
    end else begin
      r_key         <= keypad;
      r_key_prev    <= r_key;
      r_startn      <= startn;
      r_startn_prev <= r_startn;
      r_stopn       <= stopn;
      r_stopn_prev  <= r_stopn;
      r_door        <= door_closed;
      r_power       <= power;
    end
  end

  // A key only counts when the pad was released on the previous sample.
  assign w_start     = r_startn_prev & ~r_startn;
  assign w_stop      = r_stopn_prev & ~r_stopn;
  assign w_key_press = (r_key_prev == 10'd0) && is_onehot10(r_key);
  assign w_key_digit = key_digit(r_key);

  // Tens of seconds wrap to 5 on borrow; every other digit wraps to 9.
  always_comb begin : p_dec
    logic w_borrow;
    w_borrow    = 1'b1;
    w_time_zero = 1'b1;
    w_dec_zero  = 1'b1;
    for (int i = 0; i < ND; i++) begin
      w_dec[i] = r_dig[i];
      if (w_borrow) begin
        if (r_dig[i] == 4'd0) begin
          w_dec[i] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          w_dec[i] = r_dig[i] - 4'd1;
          w_borrow = 1'b0;
        end
      end else begin
        w_dec[i] = r_dig[i];
      end
      w_time_zero = w_time_zero && (r_dig[i] == 4'd0);
      w_dec_zero  = w_dec_zero && (w_dec[i] == 4'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state     <= ST_IDLE;
      r_tick      <= '0;
      r_sdiv      <= '0;
      r_sub       <= 4'd0;
      r_power_lat <= 4'd0;
      for (int i = 0; i < ND; i++) r_dig[i] <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_stop) begin
            for (int i = 0; i < ND; i++) r_dig[i] <= 4'd0;
          end else if (w_start && r_door && !w_time_zero) begin
            r_state     <= ST_COOK;
            r_tick      <= '0;
            r_sdiv      <= '0;
            r_sub       <= 4'd0;
            r_power_lat <= clamp_power(r_power);
          end else if (w_key_press) begin
            for (int i = ND - 1; i > 0; i--) r_dig[i] <= r_dig[i-1];
            r_dig[0] <= w_key_digit;
          end
        end
        ST_COOK: begin
          // Stop or door open wins over a coincident tick, which is dropped.
          if (w_stop || !r_door) begin
            r_state <= ST_PAUSE;
            r_tick  <= '0;
            r_sdiv  <= '0;
            r_sub   <= 4'd0;
          end else begin
            if (r_tick == TICK_LAST) begin
              r_tick <= '0;
              r_dig  <= w_dec;
              if (w_dec_zero) r_state <= ST_DONE;
            end else begin
              r_tick <= r_tick + TICK_W'(1);
            end
            if (r_sdiv == SDIV_LAST) begin
              r_sdiv <= '0;
              r_sub  <= (r_sub == 4'd9) ? 4'd0 : r_sub + 4'd1;
            end else begin
              r_sdiv <= r_sdiv + SDIV_W'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (w_stop) begin
            r_state <= ST_IDLE;
            for (int i = 0; i < ND; i++) r_dig[i] <= 4'd0;
          end else if (w_start && r_door) begin
            r_state     <= ST_COOK;
            r_tick      <= '0;
            r_sdiv      <= '0;
            r_sub       <= 4'd0;
            r_power_lat <= clamp_power(r_power);
          end
        end
        ST_DONE: begin
          if (w_key_press) begin
            r_state <= ST_IDLE;
            for (int i = 1; i < ND; i++) r_dig[i] <= 4'd0;
            r_dig[0] <= w_key_digit;
          end else if (w_stop || !r_door) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mag_on = (r_state == ST_COOK) && r_door && (r_sub <= r_power_lat);
  assign done   = (r_state == ST_DONE);

`ifdef DONE_BEEP_EN
  localparam int BEEP_CYC = BEEP_SECS * TICK_DIV;
  localparam int BEEP_W   = $clog2(BEEP_CYC + 1);
  localparam logic [BEEP_W-1:0] BEEP_END = BEEP_W'(BEEP_CYC);

  logic [BEEP_W-1:0] r_beep_cnt;

  // Counter idles at zero outside DONE and saturates once the beep window ends.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_beep_cnt <= '0;
    end else if (r_state != ST_DONE) begin
      r_beep_cnt <= '0;
    end else if (r_beep_cnt != BEEP_END) begin
      r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
    end
  end

  assign beep = (r_state == ST_DONE) && (r_beep_cnt != BEEP_END);
`else
  assign beep = 1'b0;
`endif

  bcd_to_7seg u_sec_ones (.i_bcd(r_dig[0]), .o_seg(sec_ones));
  bcd_to_7seg u_sec_tens (.i_bcd(r_dig[1]), .o_seg(sec_tens));

  for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min
    bcd_to_7seg u_min (.i_bcd(r_dig[g+2]), .o_seg(mins[7*g +: 7]));
  end

endmodule

// File: tb/tb_nivel2.sv
// Self-checking bench for nivel2: directed scenarios with literal expectations
// plus randomized stimulus compared every cycle against a behavioural model.
module tb_nivel2;

  localparam int TICK_DIV   = 20;
  localparam int MIN_DIGITS = 1;
  localparam int BEEP_SECS  = 3;
  localparam int NMOD       = 10 ** (MIN_DIGITS + 2);
  localparam int S_IDLE = 0, S_COOK = 1, S_PAUSE = 2, S_DONE = 3;

  logic                    clk = 1'b0;
  logic                    clear;
  logic [9:0]              keypad;
  logic                    startn, stopn, door_closed;
  logic [3:0]              power;
  logic [6:0]              sec_ones, sec_tens;
  logic [7*MIN_DIGITS-1:0] mins;
  logic                    mag_on, done, beep;

  int n_checks = 0;
  int n_pass   = 0;

  nivel2 #(.TICK_DIV(TICK_DIV), .MIN_DIGITS(MIN_DIGITS), .BEEP_SECS(BEEP_SECS)) dut (
    .clock(clk), .clear(clear), .keypad(keypad), .startn(startn), .stopn(stopn),
    .door_closed(door_closed), .power(power), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .mins(mins), .mag_on(mag_on), .done(done), .beep(beep)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Behavioural model: time held as the entered decimal number m*100+ss.
  int         m_st, m_n, m_c, m_pw, m_dc;
  bit         m_valid = 1'b0;
  logic       q1_startn, q1_stopn, q1_door, q2_startn, q2_stopn;
  logic [9:0] q1_key, q2_key;
  int         q1_power;
  logic [6:0] e_ones, e_tens, e_mins;
  logic       e_mag, e_done, e_beep;

  always @(posedge clk) begin
    bit start_ev, stop_ev, key_ev;
    int kd, mm, ss;
    if (clear) begin
      m_st = S_IDLE; m_n = 0; m_c = 0; m_pw = 0; m_dc = 0;
      q1_startn = 1'b1; q1_stopn = 1'b1; q1_key = 10'd0; q1_door = 1'b0; q1_power = 0;
      q2_startn = 1'b1; q2_stopn = 1'b1; q2_key = 10'd0;
    end else begin
      start_ev = q2_startn && !q1_startn;
      stop_ev  = q2_stopn && !q1_stopn;
      key_ev   = (q2_key == 10'd0) && ($countones(q1_key) == 1);
      kd = 0;
      for (int b = 0; b < 10; b++) if (q1_key[b]) kd = b;
      case (m_st)
        S_IDLE: begin
          if (stop_ev) m_n = 0;
          else if (start_ev && q1_door && m_n != 0) begin
            m_st = S_COOK; m_c = 0; m_pw = (q1_power > 9) ? 9 : q1_power;
          end else if (key_ev) m_n = (m_n * 10 + kd) % NMOD;
        end
        S_COOK: begin
          if (stop_ev || !q1_door) m_st = S_PAUSE;
          else begin
            m_c++;
            if (m_c == TICK_DIV) begin
              m_c = 0;
              mm = m_n / 100; ss = m_n % 100;
              if (ss > 0) ss--; else begin ss = 59; mm--; end
              m_n = mm * 100 + ss;
              if (m_n == 0) begin m_st = S_DONE; m_dc = 0; end
            end
          end
        end
        S_PAUSE: begin
          if (stop_ev) begin m_n = 0; m_st = S_IDLE; end
          else if (start_ev && q1_door) begin
            m_st = S_COOK; m_c = 0; m_pw = (q1_power > 9) ? 9 : q1_power;
          end
        end
        default: begin
          if (key_ev) begin m_n = kd; m_st = S_IDLE; end
          else if (stop_ev || !q1_door) m_st = S_IDLE;
          else m_dc++;
        end
      endcase
      q2_startn = q1_startn; q2_stopn = q1_stopn; q2_key = q1_key;
      q1_startn = startn; q1_stopn = stopn; q1_key = keypad;
      q1_door = door_closed; q1_power = int'(power);
    end
    e_ones = seg(m_n % 10);
    e_tens = seg((m_n / 10) % 10);
    e_mins = seg((m_n / 100) % 10);
    e_mag  = (m_st == S_COOK) && q1_door && ((m_c / (TICK_DIV / 10)) <= m_pw);
    e_done = (m_st == S_DONE);
`ifdef DONE_BEEP_EN
    e_beep = (m_st == S_DONE) && (m_dc < BEEP_SECS * TICK_DIV);
`else
    e_beep = 1'b0;
`endif
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_checks++;
      if (sec_ones === e_ones && sec_tens === e_tens && mins === e_mins &&
          mag_on === e_mag && done === e_done && beep === e_beep) begin
        n_pass++;
      end else begin
        $display("FAIL model_cmp t=%0t: got ones=%h tens=%h mins=%h mag=%b done=%b beep=%b, expected ones=%h tens=%h mins=%h mag=%b done=%b beep=%b",
                 $time, sec_ones, sec_tens, mins, mag_on, done, beep,
                 e_ones, e_tens, e_mins, e_mag, e_done, e_beep);
      end
    end
  end

  task automatic chk_seg(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic press_key(input int d);
    keypad = 10'(1 << d);
    repeat (2) @(negedge clk);
    keypad = 10'd0;
    repeat (2) @(negedge clk);
  endtask

  // Returns on the negedge after the second posedge following the fall.
  task automatic pulse_start();
    startn = 1'b0;
    repeat (2) @(negedge clk);
    startn = 1'b1;
  endtask

  task automatic pulse_stop();
    stopn = 1'b0;
    repeat (2) @(negedge clk);
    stopn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, w;
    clear = 1'b1; keypad = 10'd0; startn = 1'b1; stopn = 1'b1;
    door_closed = 1'b1; power = 4'd4;
    repeat (3) @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk_seg("reset_ones", sec_ones, 7'b0111111);
    chk_seg("reset_tens", sec_tens, 7'b0111111);
    chk_seg("reset_mins", mins, 7'b0111111);
    chk_bit("reset_mag", mag_on, 1'b0);
    chk_bit("reset_done", done, 1'b0);

    // 2:59 countdown
    press_key(2); press_key(5); press_key(9);
    chk_seg("e259_mins", mins, 7'h5B);
    chk_seg("e259_tens", sec_tens, 7'h6D);
    chk_seg("e259_ones", sec_ones, 7'h6F);
    pulse_start();
    chk_bit("cook_entry_mag", mag_on, 1'b1);
    repeat (19) @(negedge clk);
    chk_seg("before_first_dec", sec_ones, 7'h6F);
    @(negedge clk);
    chk_seg("first_dec_258", sec_ones, 7'h7F);
    repeat (180) @(negedge clk);
    chk_seg("t249_tens", sec_tens, 7'h66);
    chk_seg("t249_ones", sec_ones, 7'h6F);
    repeat (1000) @(negedge clk);
    chk_seg("t159_mins", mins, 7'h06);
    chk_seg("t159_tens", sec_tens, 7'h6D);
    chk_seg("t159_ones", sec_ones, 7'h6F);
    pulse_stop(); pulse_stop();
    chk_seg("stop2_ones", sec_ones, 7'h3F);
    chk_seg("stop2_mins", mins, 7'h3F);

    // Top digits discarded: 2,5,9,9,9 -> 9:99
    press_key(2); press_key(5); press_key(9); press_key(9); press_key(9);
    chk_seg("e999_mins", mins, 7'h6F);
    chk_seg("e999_tens", sec_tens, 7'h6F);
    pulse_start();
    repeat (20) @(negedge clk);
    chk_seg("t998_ones", sec_ones, 7'h7F);
    repeat (160) @(negedge clk);
    chk_seg("t990_ones", sec_ones, 7'h3F);
    repeat (20) @(negedge clk);
    chk_seg("t989_tens", sec_tens, 7'h7F);
    chk_seg("t989_mins", mins, 7'h6F);
    pulse_stop(); pulse_stop();

    // 0:03 at power 4: half duty, then DONE
    press_key(3);
    power = 4'd4;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cnt += int'(mag_on);
      @(negedge clk);
    end
    chk_int("duty_p4_cycles", cnt, 10);
    w = 0;
    while (!done && w < 200) begin @(negedge clk); w++; end
    chk_bit("done_reached", done, 1'b1);
    chk_bit("done_mag", mag_on, 1'b0);
    chk_seg("done_ones", sec_ones, 7'h3F);
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      cnt += int'(beep);
      @(negedge clk);
    end
`ifdef DONE_BEEP_EN
    chk_int("beep_cycles", cnt, BEEP_SECS * TICK_DIV);
`else
    chk_int("beep_cycles", cnt, 0);
`endif
    press_key(7);
    chk_bit("done_key_idle", done, 1'b0);
    chk_seg("done_key_digit", sec_ones, 7'h07);

    // Door open pauses at 1:30, resume after close + start
    pulse_stop();
    press_key(1); press_key(3); press_key(0);
    pulse_start();
    repeat (3) @(negedge clk);
    door_closed = 1'b0;
    @(negedge clk);
    chk_bit("door_open_mag", mag_on, 1'b0);
    repeat (50) @(negedge clk);
    chk_seg("pause_tens", sec_tens, 7'h4F);
    chk_seg("pause_ones", sec_ones, 7'h3F);
    door_closed = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start();
    chk_bit("resume_mag", mag_on, 1'b1);
    repeat (19) @(negedge clk);
    chk_seg("resume_hold", sec_ones, 7'h3F);
    @(negedge clk);
    chk_seg("resume_129", sec_tens, 7'h5B);
    pulse_stop(); pulse_stop();
    chk_seg("pause_stop_zero", sec_tens, 7'h3F);

    // Simultaneous start/stop, start with door open, multi-hot key
    press_key(5);
    startn = 1'b0; stopn = 1'b0;
    repeat (2) @(negedge clk);
    startn = 1'b1; stopn = 1'b1;
    repeat (2) @(negedge clk);
    chk_seg("start_stop_zero", sec_ones, 7'h3F);
    chk_bit("start_stop_mag", mag_on, 1'b0);
    press_key(5);
    door_closed = 1'b0;
    pulse_start();
    repeat (30) @(negedge clk);
    chk_seg("door_open_start_ignored", sec_ones, 7'h6D);
    keypad = 10'b0000000011;
    repeat (3) @(negedge clk);
    keypad = 10'd0;
    repeat (3) @(negedge clk);
    chk_seg("multihot_ignored", sec_ones, 7'h6D);
    chk_seg("multihot_tens", sec_tens, 7'h3F);
    door_closed = 1'b1;
    @(negedge clk);

    // Clear during cook
    pulse_start();
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    chk_seg("clr_ones", sec_ones, 7'b0111111);
    chk_bit("clr_mag", mag_on, 1'b0);
    chk_bit("clr_done", done, 1'b0);
    clear = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      startn = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
      stopn  = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 7) == 0) keypad = 10'(1 << $urandom_range(0, 9));
      else if ($urandom_range(0, 63) == 0) keypad = 10'($urandom);
      else keypad = 10'd0;
      if ($urandom_range(0, 99) == 0) door_closed = ~door_closed;
      if ($urandom_range(0, 49) == 0) power = 4'($urandom_range(0, 15));
      clear = ($urandom_range(0, 799) == 0) && startn && stopn && (keypad == 10'd0);
    end
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
